// File: rtl/kbd_pkg.sv
// Shared types and byte constants for the PS/2 set-2 key event decoder.
package kbd_pkg;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } kbd_state_t;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Keyboard status/ack bytes carry no key information.
    function automatic logic is_status(input logic [7:0] b);
        return (b == SC_AA) || (b == SC_FA) || (b == SC_EE) || (b == SC_FE);
    endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Pop while empty is ignored; a push while full is dropped unless a pop frees the slot the same cycle.
module kbd_evt_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic          full, pop_ok, push_ok;

    always_comb begin
        full    = (level_q == LW'(DEPTH));
        empty   = (level_q == '0);
        pop_ok  = pop && !empty;
        push_ok = push_vld && (!full || pop_ok);
        drop    = push_vld && full && !pop_ok;
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        if (clr) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_dat;
    end

    assign head_dat = mem_q[rd_q];
    assign level    = level_q;

endmodule

// File: rtl/kbd_evt_q.sv
// PS/2 set-2 byte stream to key-event queue: E0/F0/E1 collapse, timeout, repeat filter, FWFT output.
// Event visible two cycles after its final byte; consumer stalls via evt_ready, full FIFO drops and flags ovf.
module kbd_evt_q
    import kbd_pkg::*;
#(
    parameter int P_DEPTH       = 8,
    parameter int P_TIMEOUT     = 1_000_000,
    parameter bit P_DROP_REPEAT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 scode,
    input  logic                       scode_en,
    input  logic                       clr,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [7:0]                 evt_code,
    output logic                       evt_ext,
    output logic                       evt_brk,
    output logic [$clog2(P_DEPTH):0]   evt_level,
    output logic                       ovf,
    output logic                       seq_abort,
    output logic                       line_err
);

    localparam int TW = $clog2(P_TIMEOUT);

    kbd_state_t    state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          abort_q, abort_d;
    logic          line_err_q, line_err_d;
    logic          ovf_q, ovf_d;
    logic          push_vld_q, push_vld_d;
    kbd_evt_t      push_dat_q, push_dat_d;
    logic          emit, pause_evt, drop_rep, fifo_drop, fifo_empty;
    kbd_evt_t      emit_dat, head;

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        tmo_d      = '0;
        abort_d    = 1'b0;
        line_err_d = line_err_q;
        emit       = 1'b0;
        pause_evt  = 1'b0;
        emit_dat   = '{ext: 1'b0, brk: 1'b0, code: scode};
        if (scode_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (scode == SC_E0)      state_d = ST_EXT;
                    else if (scode == SC_F0) state_d = ST_BRK;
                    else if (scode == SC_E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end
                    else if (scode == SC_00 || scode == SC_FF) line_err_d = 1'b1;
                    else if (!is_status(scode))                emit       = 1'b1;
                end
                ST_EXT: begin
                    state_d = ST_IDLE;
                    if (scode == SC_F0) state_d = ST_EXT_BRK;
                    else if (scode != SC_E0 && scode != SC_E1) begin
                        emit     = 1'b1;
                        emit_dat = '{ext: 1'b1, brk: 1'b0, code: scode};
                    end
                end
                ST_BRK: begin
                    state_d  = ST_IDLE;
                    emit     = 1'b1;
                    emit_dat = '{ext: 1'b0, brk: 1'b1, code: scode};
                end
                ST_EXT_BRK: begin
                    state_d  = ST_IDLE;
                    emit     = 1'b1;
                    emit_dat = '{ext: 1'b1, brk: 1'b1, code: scode};
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d   = ST_IDLE;
                        emit      = 1'b1;
                        pause_evt = 1'b1;
                        emit_dat  = '{ext: 1'b1, brk: 1'b0, code: SC_E1};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A byte in the deadline cycle takes the branch above, so it always wins over the abort.
            if (tmo_q == TW'(P_TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                abort_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
        push_vld_d = emit && !drop_rep;
        push_dat_d = emit_dat;
        ovf_d      = ovf_q | fifo_drop;
        if (clr) begin
            state_d    = ST_IDLE;
            skip_d     = '0;
            tmo_d      = '0;
            abort_d    = 1'b0;
            line_err_d = 1'b0;
            ovf_d      = 1'b0;
            push_vld_d = 1'b0;
            push_dat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            tmo_q      <= '0;
            abort_q    <= 1'b0;
            line_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            push_vld_q <= 1'b0;
            push_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            abort_q    <= abort_d;
            line_err_q <= line_err_d;
            ovf_q      <= ovf_d;
            push_vld_q <= push_vld_d;
            push_dat_q <= push_dat_d;
        end
    end

    if (P_DROP_REPEAT) begin : g_filt
        logic       held_q, held_d, hext_q, hext_d, match;
        logic [7:0] hcode_q, hcode_d;

        always_comb begin
            held_d   = held_q;
            hcode_d  = hcode_q;
            hext_d   = hext_q;
            drop_rep = 1'b0;
            match    = held_q && (hcode_q == emit_dat.code) && (hext_q == emit_dat.ext);
            if (emit && !pause_evt) begin
                if (!emit_dat.brk) begin
                    if (match) drop_rep = 1'b1;
                    else begin
                        held_d  = 1'b1;
                        hcode_d = emit_dat.code;
                        hext_d  = emit_dat.ext;
                    end
                end else if (match) begin
                    held_d = 1'b0;
                end
            end
            if (clr) begin
                held_d  = 1'b0;
                hcode_d = '0;
                hext_d  = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                held_q  <= 1'b0;
                hcode_q <= '0;
                hext_q  <= 1'b0;
            end else begin
                held_q  <= held_d;
                hcode_q <= hcode_d;
                hext_q  <= hext_d;
            end
        end
    end else begin : g_nofilt
        assign drop_rep = 1'b0;
    end

    kbd_evt_fifo #(
        .W     ($bits(kbd_evt_t)),
        .DEPTH (P_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .push_vld (push_vld_q),
        .push_dat (push_dat_q),
        .pop      (evt_ready),
        .head_dat (head),
        .empty    (fifo_empty),
        .level    (evt_level),
        .drop     (fifo_drop)
    );

    // Head fields read as zero while empty so flush/reset values are deterministic.
    assign evt_valid = !fifo_empty;
    assign evt_code  = evt_valid ? head.code : 8'h00;
    assign evt_ext   = evt_valid & head.ext;
    assign evt_brk   = evt_valid & head.brk;
    assign ovf       = ovf_q;
    assign seq_abort = abort_q;
    assign line_err  = line_err_q;

endmodule

// File: tb/tb_kbd_evt_q.sv
// Directed bench: A = depth 4 with repeat filter, B = depth 8 without; both share stimulus.
module tb_kbd_evt_q;

    logic       clk = 1'b0;
    logic       rst_n, scode_en, clr, evt_ready;
    logic [7:0] scode;

    logic       a_valid, a_ext, a_brk, a_ovf, a_abort, a_lerr;
    logic [7:0] a_code;
    logic [2:0] a_level;
    logic       b_valid, b_ext, b_brk, b_ovf, b_abort, b_lerr;
    logic [7:0] b_code;
    logic [3:0] b_level;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    kbd_evt_q #(.P_DEPTH(4), .P_TIMEOUT(16), .P_DROP_REPEAT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .scode(scode), .scode_en(scode_en), .clr(clr),
        .evt_valid(a_valid), .evt_ready(evt_ready), .evt_code(a_code), .evt_ext(a_ext),
        .evt_brk(a_brk), .evt_level(a_level), .ovf(a_ovf), .seq_abort(a_abort), .line_err(a_lerr)
    );

    kbd_evt_q #(.P_DEPTH(8), .P_TIMEOUT(16), .P_DROP_REPEAT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .scode(scode), .scode_en(scode_en), .clr(clr),
        .evt_valid(b_valid), .evt_ready(evt_ready), .evt_code(b_code), .evt_ext(b_ext),
        .evt_brk(b_brk), .evt_level(b_level), .ovf(b_ovf), .seq_abort(b_abort), .line_err(b_lerr)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; consecutive calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        scode    = b;
        scode_en = 1'b1;
        @(posedge clk);
        #1;
        scode_en = 1'b0;
        scode    = 8'h00;
    endtask

    task automatic pop_evt(output logic [9:0] e);
        @(negedge clk);
        e         = {a_ext, a_brk, a_code};
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; scode_en = 1'b0; scode = 8'h00; evt_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (a_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", a_valid); else n_pass++;
        n_chk++; if (a_level !== 3'd0) $display("FAIL rst_level got %0d want 0", a_level); else n_pass++;
        n_chk++;
        if ({a_code, a_ext, a_brk, a_ovf, a_abort, a_lerr} !== 13'h0)
            $display("FAIL rst_outputs got %h want 0", {a_code, a_ext, a_brk, a_ovf, a_abort, a_lerr});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [9:0] e;
        send(8'h1C);
        @(negedge clk);
        n_chk++; if (a_valid !== 1'b0) $display("FAIL lat_early_valid got %b want 0", a_valid); else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({a_valid, a_ext, a_brk, a_code, a_level} !== {1'b1, 1'b0, 1'b0, 8'h1C, 3'd1})
            $display("FAIL lat_first got v%b e%b b%b %h L%0d want v1 e0 b0 1c L1", a_valid, a_ext, a_brk, a_code, a_level);
        else n_pass++;
        @(posedge clk); #1;
        send(8'hF0);
        send(8'h1C);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd1) $display("FAIL lat_level_n1 got %0d want 1", a_level); else n_pass++;
        @(negedge clk);
        n_chk++; if (a_level !== 3'd2) $display("FAIL lat_level_n2 got %0d want 2", a_level); else n_pass++;
        @(posedge clk); #1;
        pop_evt(e);
        n_chk++; if (e !== 10'h01C) $display("FAIL lat_pop_make got %h want 01c", e); else n_pass++;
        pop_evt(e);
        n_chk++; if (e !== 10'h11C) $display("FAIL lat_pop_break got %h want 11c", e); else n_pass++;
        @(negedge clk);
        n_chk++; if (a_valid !== 1'b0) $display("FAIL lat_drained got %b want 0", a_valid); else n_pass++;
        @(posedge clk); #1;
        do_clr();
    endtask

    task automatic test_ext();
        logic [9:0] e;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd2) $display("FAIL ext_level got %0d want 2", a_level); else n_pass++;
        @(posedge clk); #1;
        pop_evt(e);
        n_chk++; if (e !== 10'h275) $display("FAIL ext_make got %h want 275", e); else n_pass++;
        pop_evt(e);
        n_chk++; if (e !== 10'h375) $display("FAIL ext_break got %h want 375", e); else n_pass++;
        do_clr();
    endtask

    task automatic test_repeat();
        logic [9:0] e;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd2) $display("FAIL rep_filtered_level got %0d want 2", a_level); else n_pass++;
        n_chk++; if (b_level !== 4'd4) $display("FAIL rep_unfiltered_level got %0d want 4", b_level); else n_pass++;
        @(posedge clk); #1;
        pop_evt(e);
        n_chk++; if (e !== 10'h01C) $display("FAIL rep_first got %h want 01c", e); else n_pass++;
        pop_evt(e);
        n_chk++; if (e !== 10'h11C) $display("FAIL rep_second got %h want 11c", e); else n_pass++;
        do_clr();
        // Different-key break keeps 1C held, so the final 1C is a repeat.
        send(8'h1C); send(8'hF0); send(8'h32); send(8'h1C);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd2) $display("FAIL rep_other_break got %0d want 2", a_level); else n_pass++;
        @(posedge clk); #1;
        do_clr();
        send(8'h1C); send(8'h32); send(8'h1C);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd3) $display("FAIL rep_new_make got %0d want 3", a_level); else n_pass++;
        @(posedge clk); #1;
        do_clr();
    endtask

    task automatic test_pause();
        logic [7:0] pz [8];
        pz = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) send(pz[i]);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd1) $display("FAIL pause_level got %0d want 1", a_level); else n_pass++;
        n_chk++;
        if ({a_ext, a_brk, a_code} !== 10'h2E1) $display("FAIL pause_head got %h want 2e1", {a_ext, a_brk, a_code});
        else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(pz[i]);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd2) $display("FAIL pause_no_filter got %0d want 2", a_level); else n_pass++;
        @(posedge clk); #1;
        do_clr();
    endtask

    task automatic test_line_err();
        send(8'hFF);
        @(negedge clk);
        n_chk++; if (a_lerr !== 1'b1) $display("FAIL lerr_set got %b want 1", a_lerr); else n_pass++;
        @(posedge clk); #1;
        send(8'hAA); send(8'hFA); send(8'h00);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd0) $display("FAIL lerr_no_events got %0d want 0", a_level); else n_pass++;
        @(posedge clk); #1;
        do_clr();
        @(negedge clk);
        n_chk++; if (a_lerr !== 1'b0) $display("FAIL lerr_clr got %b want 0", a_lerr); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int pulses;
        int first;
        pulses = 0;
        first  = -1;
        send(8'hE0);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (a_abort === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_chk++; if (pulses != 1) $display("FAIL tmo_pulses got %0d want 1", pulses); else n_pass++;
        n_chk++; if (first != 17) $display("FAIL tmo_cycle got %0d want 17", first); else n_pass++;
        n_chk++; if (a_level !== 3'd0) $display("FAIL tmo_no_event got %0d want 0", a_level); else n_pass++;
        @(posedge clk); #1;
        send(8'h1C);
        tick(2);
        @(negedge clk);
        n_chk++;
        if ({a_valid, a_ext, a_brk, a_code} !== {1'b1, 10'h01C})
            $display("FAIL tmo_after got v%b %h want v1 01c", a_valid, {a_ext, a_brk, a_code});
        else n_pass++;
        @(posedge clk); #1;
        do_clr();
        send(8'hE0);
        tick(10);
        send(8'h75);
        tick(2);
        @(negedge clk);
        n_chk++;
        if ({a_ext, a_brk, a_code} !== 10'h275) $display("FAIL tmo_in_time got %h want 275", {a_ext, a_brk, a_code});
        else n_pass++;
        @(posedge clk); #1;
        do_clr();
    endtask

    task automatic test_overflow();
        logic [9:0] e;
        logic [7:0] exp_c [4];
        exp_c = '{8'h16, 8'h1D, 8'h24, 8'h2C};
        send(8'h15); send(8'h16); send(8'h1D); send(8'h24); send(8'h2D);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd4) $display("FAIL ovf_level got %0d want 4", a_level); else n_pass++;
        n_chk++; if (a_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", a_ovf); else n_pass++;
        n_chk++; if (a_code !== 8'h15) $display("FAIL ovf_head got %h want 15", a_code); else n_pass++;
        @(posedge clk); #1;
        send(8'h2C);
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (a_level !== 3'd4) $display("FAIL full_pushpop_level got %0d want 4", a_level); else n_pass++;
        n_chk++; if (a_code !== 8'h16) $display("FAIL full_pushpop_head got %h want 16", a_code); else n_pass++;
        n_chk++; if (a_ovf !== 1'b1) $display("FAIL full_pushpop_ovf got %b want 1", a_ovf); else n_pass++;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            pop_evt(e);
            n_chk++;
            if (e !== {2'b00, exp_c[i]}) $display("FAIL ovf_drain_%0d got %h want %h", i, e, {2'b00, exp_c[i]});
            else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (a_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", a_valid); else n_pass++;
        @(posedge clk); #1;
        do_clr();
    endtask

    task automatic test_reset_mid(input int use_clr);
        send(8'hFF);
        send(8'h1C); send(8'h32); send(8'h21);
        tick(3);
        @(negedge clk);
        n_chk++; if (a_level !== 3'd3) $display("FAIL mid%0d_queued got %0d want 3", use_clr, a_level); else n_pass++;
        @(posedge clk); #1;
        send(8'hF0);
        if (use_clr != 0) clr = 1'b1; else rst_n = 1'b0;
        @(posedge clk); #1;
        clr   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_valid, a_code, a_ext, a_brk, a_level, a_ovf, a_abort, a_lerr} !== 17'h0)
            $display("FAIL mid%0d_cleared got %h want 0", use_clr,
                     {a_valid, a_code, a_ext, a_brk, a_level, a_ovf, a_abort, a_lerr});
        else n_pass++;
        @(posedge clk); #1;
        send(8'h1C);
        tick(2);
        @(negedge clk);
        n_chk++;
        if ({a_level, a_ext, a_brk, a_code} !== {3'd1, 10'h01C})
            $display("FAIL mid%0d_make got L%0d %h want L1 01c", use_clr, a_level, {a_ext, a_brk, a_code});
        else n_pass++;
        @(posedge clk); #1;
        do_clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_ext();
        test_repeat();
        test_pause();
        test_line_err();
        test_timeout();
        test_overflow();
        test_reset_mid(0);
        test_reset_mid(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
